// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared constants and FSM state encoding for the buffered UART TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int DATA_W    = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module   : uart_fifo
// Purpose  : Show-ahead synchronous FIFO with registered count and flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_push;
    logic               w_pop;

    // Flags come from the registered count only, so a pop on the same edge
    // never frees a slot for a write that arrives while full.
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_push = i_wr_en && !o_full;
    assign w_pop  = i_rd_en && !o_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_buf_tx.sv
// ============================================================================
// Module   : uart_buf_tx
// Purpose  : FIFO-buffered UART transmitter, 8 data bits, 1 stop bit.
//            Define UART_TX_PARITY_EN to add an even-parity bit after DATA.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_buf_tx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV   = 5208,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_en,
    output logic              tx_full,
    output logic              tx_status,
    output logic              tx_overflow,
    output logic              txd
);

    localparam int        c_cnt_w     = $clog2(FIFO_DEPTH) + 1;
    localparam int        c_tmr_w     = 16;
    localparam logic [c_tmr_w-1:0] c_div_last  = c_tmr_w'(BAUD_DIV - 1);
    localparam logic [2:0]         c_stop_last = 3'(STOP_BITS - 1);

    tx_state_t          r_state;
    tx_state_t          w_state_next;
    logic [c_tmr_w-1:0] r_timer;
    logic [c_tmr_w-1:0] w_timer_next;
    logic [2:0]         r_idx;
    logic [2:0]         w_idx_next;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_next;
    logic               r_txd;
    logic               w_txd_next;
    logic               r_overflow;
    logic               w_bit_end;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_head;
    logic [c_cnt_w-1:0] w_count;

    uart_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (sysclk),
        .rst       (reset),
        .i_wr_en   (tx_en),
        .i_wr_data (tx_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    assign w_bit_end   = (r_timer == c_div_last);
    assign tx_full     = w_full;
    assign tx_status   = (r_state == ST_IDLE) && (w_count == '0);
    assign tx_overflow = r_overflow;
    assign txd         = r_txd;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_timer    <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_txd      <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_timer    <= w_timer_next;
            r_idx      <= w_idx_next;
            r_shift    <= w_shift_next;
            r_txd      <= w_txd_next;
            r_overflow <= tx_en && w_full;
        end
    end

    // The line level is registered from the current state, so txd trails
    // the state register by one cycle.
    always_comb begin
        w_state_next = r_state;
        w_timer_next = w_bit_end ? '0 : r_timer + c_tmr_w'(1);
        w_idx_next   = r_idx;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        w_txd_next   = 1'b1;

        case (r_state)
            ST_IDLE: begin
                w_timer_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                w_txd_next = 1'b0;
                if (w_bit_end) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                w_txd_next = r_shift[r_idx];
                if (w_bit_end) begin
                    w_idx_next = r_idx + 3'd1;
                    if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                w_txd_next = ^r_shift;
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_idx == c_stop_last) begin
                        w_idx_next = '0;
                        if (!w_empty) begin
                            w_pop        = 1'b1;
                            w_shift_next = w_head;
                            w_state_next = ST_START;
                        end else begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_idx_next = r_idx + 3'd1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_timer_next = '0;
                w_idx_next   = '0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_buf_tx.sv
// ============================================================================
// Module   : tb_uart_buf_tx
// Purpose  : Self-checking bench for uart_buf_tx against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_buf_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = BAUD * 11;
`else
    localparam int FRAME = BAUD * 10;
`endif

    logic       sysclk = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_en   = 1'b0;
    logic       tx_full;
    logic       tx_status;
    logic       tx_overflow;
    logic       txd;

    uart_buf_tx #(
        .BAUD_DIV   (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .sysclk      (sysclk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_en       (tx_en),
        .tx_full     (tx_full),
        .tx_status   (tx_status),
        .tx_overflow (tx_overflow),
        .txd         (txd)
    );

    always #5 sysclk = ~sysclk;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Reference model: queued bytes, scheduled frames, and the edge at which
    // the transmitter is free to take the next byte.
    int         n      = 0;
    int         t_free = 0;
    logic       exp_ovf = 1'b0;
    logic [7:0] m_q[$];
    int         f_start[$];
    logic [7:0] f_byte[$];

    task automatic check(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed %b expected %b", tag, n, obs, exp);
        end
    endtask

    task automatic model_edge(input logic en, input logic [7:0] d);
        bit full_pre;
        bit pop;
        n++;
        full_pre = (m_q.size() == DEPTH);
        pop      = (m_q.size() > 0) && (n >= t_free);
        exp_ovf  = en && full_pre;
        if (pop) begin
            f_start.push_back(n + 1);
            f_byte.push_back(m_q.pop_front());
            t_free = n + FRAME;
        end
        if (en && !full_pre) begin
            m_q.push_back(d);
        end
    endtask

    task automatic check_outputs();
        logic e_txd;
        int   k;
        while (f_start.size() > 0 && n >= f_start[0] + FRAME) begin
            void'(f_start.pop_front());
            void'(f_byte.pop_front());
        end
        e_txd = 1'b1;
        if (f_start.size() > 0 && n >= f_start[0]) begin
            k = (n - f_start[0]) / BAUD;
            if (k == 0) begin
                e_txd = 1'b0;
            end else if (k <= 8) begin
                e_txd = f_byte[0][k-1];
`ifdef UART_TX_PARITY_EN
            end else if (k == 9) begin
                e_txd = ^f_byte[0];
`endif
            end
        end
        check("txd", txd, e_txd);
        check("tx_full", tx_full, logic'(m_q.size() == DEPTH));
        check("tx_status", tx_status, logic'((n >= t_free) && (m_q.size() == 0)));
        check("tx_overflow", tx_overflow, exp_ovf);
    endtask

    task automatic tick(input logic en, input logic [7:0] d);
        tx_en   = en;
        tx_data = d;
        @(posedge sysclk);
        if (!reset) begin
            model_edge(en, d);
        end
        @(negedge sysclk);
        check_outputs();
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick(1'b0, 8'($urandom));
        end
    endtask

    // Entered just after a falling edge; reset is raised between edges so the
    // asynchronous outputs are observed before any clock edge.
    task automatic do_reset(input int cycles);
        #2;
        reset = 1'b1;
        tx_en = 1'b0;
        #1;
        m_q.delete();
        f_start.delete();
        f_byte.delete();
        exp_ovf = 1'b0;
        check("rst_txd", txd, 1'b1);
        check("rst_status", tx_status, 1'b1);
        check("rst_full", tx_full, 1'b0);
        check("rst_overflow", tx_overflow, 1'b0);
        for (int i = 0; i < cycles; i++) begin
            @(posedge sysclk);
            n++;
        end
        @(negedge sysclk);
        reset  = 1'b0;
        t_free = n;
        check_outputs();
    endtask

    initial begin
        @(negedge sysclk);
        do_reset(3);

        // single byte, written on the first edge after reset release
        tick(1'b1, 8'h55);
        idle(50);

        // three bytes back to back
        tick(1'b1, 8'h01);
        tick(1'b1, 8'h02);
        tick(1'b1, 8'h03);
        idle(3 * FRAME + 10);

        // six consecutive writes: fifth fills the buffer, sixth overflows
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 8'(8'h10 + i));
        end
        idle(5 * FRAME + 10);

        // reset 13 cycles into an 0xA3 frame with two bytes queued
        tick(1'b1, 8'hA3);
        tick(1'b1, 8'h5C);
        tick(1'b1, 8'hE1);
        idle(12);
        do_reset(2);
        idle(100);

`ifdef UART_TX_PARITY_EN
        tick(1'b1, 8'h07);
        idle(FRAME + 10);
        tick(1'b1, 8'h03);
        idle(FRAME + 10);
`endif

        // randomized bursts with gaps, including writes while full
        for (int b = 0; b < 8; b++) begin
            int len;
            len = int'($urandom_range(1, 7));
            for (int i = 0; i < len; i++) begin
                tick(1'b1, 8'($urandom));
                if ($urandom_range(0, 3) == 0) begin
                    idle(int'($urandom_range(1, 3)));
                end
            end
            idle(int'($urandom_range(0, 150)));
        end
        idle(6 * FRAME + 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
